// File: rtl/btle_tx_pkg.sv
// Shared BLE transmit definitions: scheduler FSM states, bit-period
// derivation and the data-whitening LFSR seed/tap constants.
package btle_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_e;

  // Whitening LFSR geometry: 7 stages, feedback XOR into stage 4.
  localparam int WHITEN_W       = 7;
  localparam int WHITEN_XOR_TAP = 4;

  // One bit lasts two symbols' worth of upsampler samples.
  function automatic int clk_per_bit(input int sample_per_symbol);
    return 2 * sample_per_symbol;
  endfunction

  // Seed: w[0] = 1, w[1..6] = channel_number[5..0] (bit-reversed channel).
  function automatic logic [WHITEN_W-1:0] whiten_seed(input logic [5:0] channel);
    logic [WHITEN_W-1:0] seed;
    seed[0] = 1'b1;
    for (int k = 1; k < WHITEN_W; k++) begin
      seed[k] = channel[6-k];
    end
    return seed;
  endfunction

endpackage

// File: rtl/ble_whiten_lfsr.sv
// BLE data-whitening LFSR. Output bit is the top stage; each step shifts
// the register up by one with the top stage fed back into stage 0 and
// XORed into stage 4. A load overrides a step.
module ble_whiten_lfsr
  import btle_tx_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WHITEN_W-1:0] seed,
  input  logic                step,
  output logic                out_bit
);

  logic [WHITEN_W-1:0] w_q;
  logic [WHITEN_W-1:0] w_d;

  // Next LFSR contents: seed on load, advance on step, otherwise hold.
  always_comb begin
    w_d = w_q;
    if (load) begin
      w_d = seed;
    end else if (step) begin
      for (int k = 1; k < WHITEN_W; k++) begin
        w_d[k] = w_q[k-1];
      end
      w_d[0]              = w_q[WHITEN_W-1];
      w_d[WHITEN_XOR_TAP] = w_q[WHITEN_XOR_TAP-1] ^ w_q[WHITEN_W-1];
    end
  end

  // LFSR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign out_bit = w_q[WHITEN_W-1];

endmodule

// File: rtl/tx_bit_scheduler.sv
// BLE transmit bit scheduler: accepts packet bytes through a one-byte
// prefetch register and emits one LSB-first bit every CLK_PER_BIT clocks
// toward the upsampler. Optional whitening is enabled by TX_WHITENING_EN.
module tx_bit_scheduler
  import btle_tx_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] pdu_len,
  input  logic [5:0] channel_number,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       phy_bit,
  output logic       bit_valid,
  output logic       bit_valid_last,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int CLK_PER_BIT = clk_per_bit(SAMPLE_PER_SYMBOL);
  localparam int CNT_W       = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

  tx_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;          // clocks since the last bit (or since DRAIN entry)
  logic [7:0] rem_q, rem_d;                // bytes still to be transferred in
  logic [7:0] shreg_q, shreg_d;            // unsent bits of the current byte, LSB next
  logic [2:0] bits_left_q, bits_left_d;    // how many bits remain in shreg
  logic [7:0] pf_q, pf_d;                  // prefetch register
  logic       pf_valid_q, pf_valid_d;
  logic       phy_bit_q, phy_bit_d;
  logic       bit_valid_q, bit_valid_d;
  logic       last_q, last_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;

  logic       accept;      // start accepted with a non-empty packet
  logic       xfer;        // byte handshake this cycle
  logic       emit;        // a bit is launched at the coming edge
  logic       emit_data;   // unwhitened value of that bit
  logic       byte_ready_w;

  assign accept = (state_q == ST_IDLE) && start && (pdu_len != 8'd0);

  // Ready in FETCH, or in SHIFT while the prefetch slot is free and bytes remain.
  assign byte_ready_w = (state_q == ST_FETCH) ||
                        ((state_q == ST_SHIFT) && !pf_valid_q && (rem_q != 8'd0));
  assign xfer = byte_valid && byte_ready_w;

  // Next-state and datapath control for the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    pf_d        = pf_q;
    pf_valid_d  = pf_valid_q;
    last_d      = 1'b0;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    emit        = 1'b0;
    emit_data   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_FETCH;
          rem_d      = pdu_len;
          pf_valid_d = 1'b0;
        end else if (start) begin
          done_d = 1'b1;   // empty packet completes immediately
        end
      end

      ST_FETCH: begin
        if (xfer) begin
          state_d     = ST_SHIFT;
          rem_d       = rem_q - 8'd1;
          emit        = 1'b1;
          emit_data   = byte_in[0];
          shreg_d     = {1'b0, byte_in[7:1]};
          bits_left_d = 3'd7;
          cnt_d       = '0;
        end
      end

      ST_SHIFT: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        if (xfer && (rem_q != 8'd0)) begin
          rem_d = rem_q - 8'd1;
        end
        if (cnt_q == CNT_LAST) begin
          if (bits_left_q != 3'd0) begin
            emit        = 1'b1;
            emit_data   = shreg_q[0];
            shreg_d     = {1'b0, shreg_q[7:1]};
            bits_left_d = bits_left_q - 3'd1;
            if (bits_left_q == 3'd1 && rem_q == 8'd0 && !pf_valid_q) begin
              last_d  = 1'b1;
              state_d = ST_DRAIN;
            end
            if (xfer) begin
              pf_d       = byte_in;
              pf_valid_d = 1'b1;
            end
          end else if (pf_valid_q) begin
            emit        = 1'b1;
            emit_data   = pf_q[0];
            shreg_d     = {1'b0, pf_q[7:1]};
            bits_left_d = 3'd7;
            pf_valid_d  = 1'b0;
          end else if (xfer) begin
            // A byte arriving on the boundary itself satisfies it directly.
            emit        = 1'b1;
            emit_data   = byte_in[0];
            shreg_d     = {1'b0, byte_in[7:1]};
            bits_left_d = 3'd7;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
            rem_d      = 8'd0;
            pf_valid_d = 1'b0;
          end
        end else if (xfer) begin
          pf_d       = byte_in;
          pf_valid_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bit_valid_d = emit;

`ifdef TX_WHITENING_EN
  logic whiten_bit;

  ble_whiten_lfsr u_whiten (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .seed    (whiten_seed(channel_number)),
    .step    (emit),
    .out_bit (whiten_bit)
  );

  // The emitted bit is whitened; otherwise phy_bit holds its value.
  always_comb begin
    phy_bit_d = emit ? (emit_data ^ whiten_bit) : phy_bit_q;
  end
`else
  logic unused_channel;
  assign unused_channel = ^channel_number;

  // The emitted bit goes out as-is; otherwise phy_bit holds its value.
  always_comb begin
    phy_bit_d = emit ? emit_data : phy_bit_q;
  end
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= 8'd0;
      shreg_q     <= 8'd0;
      bits_left_q <= 3'd0;
      pf_q        <= 8'd0;
      pf_valid_q  <= 1'b0;
      phy_bit_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      pf_q        <= pf_d;
      pf_valid_q  <= pf_valid_d;
      phy_bit_q   <= phy_bit_d;
      bit_valid_q <= bit_valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign byte_ready     = byte_ready_w;
  assign phy_bit        = phy_bit_q;
  assign bit_valid      = bit_valid_q;
  assign bit_valid_last = last_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_tx_bit_scheduler.sv
// Testbench for tx_bit_scheduler. Whitening scenario runs when
// TX_WHITENING_EN is defined.
module tb_tx_bit_scheduler;

  localparam int SPS = 8;
  localparam int CPB = 2 * SPS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pdu_len = 8'd0;
  logic [5:0] channel_number = 6'd0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, phy_bit, bit_valid, bit_valid_last, busy, done, underrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   bv_t[$];
  logic bv_b[$];
  int   last_t[$];
  int   done_t[$];
  int   und_t[$];
  int   xfer_t[$];
  int   hold_err = 0;
  logic prev_phy = 1'b0;
  logic [7:0] pkt[$];

  tx_bit_scheduler #(.SAMPLE_PER_SYMBOL(SPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pdu_len        (pdu_len),
    .channel_number (channel_number),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .phy_bit        (phy_bit),
    .bit_valid      (bit_valid),
    .bit_valid_last (bit_valid_last),
    .busy           (busy),
    .done           (done),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bit_valid === 1'b1) begin
      bv_t.push_back(cyc);
      bv_b.push_back(phy_bit);
    end else if (phy_bit !== prev_phy) begin
      hold_err++;
    end
    if (bit_valid_last === 1'b1) last_t.push_back(cyc);
    if (done === 1'b1) done_t.push_back(cyc);
    if (underrun === 1'b1) und_t.push_back(cyc);
    if (byte_valid === 1'b1 && byte_ready === 1'b1) xfer_t.push_back(cyc);
    prev_phy = phy_bit;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    bv_t.delete(); bv_b.delete(); last_t.delete(); done_t.delete();
    und_t.delete(); xfer_t.delete(); hold_err = 0; prev_phy = phy_bit;
  endtask

  task automatic pulse_start(input logic [7:0] len, input logic [5:0] ch, output int s_cyc);
    start = 1'b1; pdu_len = len; channel_number = ch; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int delay, output bit ok);
    ok = 1'b0;
    repeat (delay) begin @(posedge clk); #1; end
    byte_in = b; byte_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 4000) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s idle_timeout: busy=%b required 0", name, busy);
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  // Reference: bit j of the packet is launched at x0+1+CPB*j; byte b must be
  // handed over no later than the boundary that needs it (x0+CPB*8*b).
  task automatic check_packet(input string name, input logic [5:0] ch);
    int n, x0, nbits, und_at, exp_last;
    logic eb[$];
    logic [6:0] w;
    logic d, wb;
    n = pkt.size();
    total++;
    if (xfer_t.size() == 0) begin
      bad++; $display("FAIL %s first_xfer: got 0 transfers, required >=1", name);
      return;
    end
    x0 = xfer_t[0]; nbits = 8 * n; und_at = -1;
    for (int b = 1; b < n; b++) begin
      if (b >= xfer_t.size() || xfer_t[b] > x0 + CPB * 8 * b) begin
        nbits = 8 * b; und_at = x0 + 1 + CPB * 8 * b; break;
      end
    end
    w[0] = 1'b1;
    for (int k = 1; k < 7; k++) w[k] = ch[6-k];
    for (int j = 0; j < nbits; j++) begin
      d = pkt[j/8][j%8];
`ifdef TX_WHITENING_EN
      eb.push_back(d ^ w[6]);
`else
      eb.push_back(d);
`endif
      wb = w[6];
      w = {w[5], w[4], w[3] ^ wb, w[2], w[1], w[0], wb};
    end
    total++;
    if (xfer_t.size() != nbits / 8) begin
      bad++; $display("FAIL %s xfer_count: got %0d required %0d", name, xfer_t.size(), nbits / 8);
    end
    for (int b = 2; b < xfer_t.size(); b++) begin
      total++;
      if (xfer_t[b] < x0 + 1 + CPB * 8 * (b - 1)) begin
        bad++; $display("FAIL %s prefetch_depth: byte %0d at %0d, earliest %0d", name, b, xfer_t[b], x0 + 1 + CPB * 8 * (b - 1));
      end
    end
    total++;
    if (bv_t.size() != nbits) begin
      bad++; $display("FAIL %s bit_count: got %0d required %0d", name, bv_t.size(), nbits);
    end
    for (int j = 0; j < nbits && j < bv_t.size(); j++) begin
      total++;
      if (bv_t[j] != x0 + 1 + CPB * j) begin
        bad++; $display("FAIL %s bit_time[%0d]: got %0d required %0d", name, j, bv_t[j], x0 + 1 + CPB * j);
      end
      total++;
      if (bv_b[j] !== eb[j]) begin
        bad++; $display("FAIL %s phy_bit[%0d]: got %b required %b", name, j, bv_b[j], eb[j]);
      end
    end
    exp_last = x0 + 1 + CPB * (nbits - 1);
    total++;
    if (und_at < 0) begin
      if (last_t.size() != 1 || last_t[0] != exp_last) begin
        bad++; $display("FAIL %s last: got %0d pulses (first %0d) required 1 at %0d", name, last_t.size(), (last_t.size() > 0) ? last_t[0] : -1, exp_last);
      end
    end else if (last_t.size() != 0) begin
      bad++; $display("FAIL %s last: got %0d pulses required 0", name, last_t.size());
    end
    total++;
    if (und_at < 0) begin
      if (done_t.size() != 1 || done_t[0] != exp_last + CPB) begin
        bad++; $display("FAIL %s done: got %0d pulses (first %0d) required 1 at %0d", name, done_t.size(), (done_t.size() > 0) ? done_t[0] : -1, exp_last + CPB);
      end
    end else if (done_t.size() != 0) begin
      bad++; $display("FAIL %s done: got %0d pulses required 0", name, done_t.size());
    end
    total++;
    if (und_at < 0) begin
      if (und_t.size() != 0) begin
        bad++; $display("FAIL %s underrun: got %0d pulses required 0", name, und_t.size());
      end
    end else if (und_t.size() != 1 || und_t[0] != und_at) begin
      bad++; $display("FAIL %s underrun: got %0d pulses (first %0d) required 1 at %0d", name, und_t.size(), (und_t.size() > 0) ? und_t[0] : -1, und_at);
    end
    total++;
    if (hold_err != 0) begin
      bad++; $display("FAIL %s phy_hold: got %0d changes outside bit_valid required 0", name, hold_err);
    end
    $display("pkt %s: len=%0d ch=%0d x0=%0d bits=%0d/%0d underrun_expected=%0d", name, n, ch, x0, bv_t.size(), nbits, (und_at >= 0));
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({byte_ready, phy_bit, bit_valid, bit_valid_last, busy, done, underrun} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b required 0000000", {byte_ready, phy_bit, bit_valid, bit_valid_last, busy, done, underrun});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release: busy=%b byte_ready=%b required 0,0", busy, byte_ready);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single_byte();
    int s; bit ok;
    clear_mon(); pkt = '{8'hA5};
    pulse_start(8'd1, 6'd0, s);
    total++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      bad++; $display("FAIL fetch_state: busy=%b byte_ready=%b required 1,1", busy, byte_ready);
    end
    send_byte(8'hA5, 3, ok);
    wait_idle("single");
    check_packet("single", 6'd0);
  endtask

  task automatic test_back_to_back();
    int s; bit ok;
    clear_mon(); pkt = '{8'h01, 8'h80, 8'hFF};
    pulse_start(8'd3, 6'd0, s);
    for (int b = 0; b < 3; b++) send_byte(pkt[b], 0, ok);
    wait_idle("b2b");
    for (int b = 1; b < 3 && b < xfer_t.size(); b++) begin
      total++;
      if (xfer_t[b] != xfer_t[0] + 1 + CPB * 8 * (b - 1)) begin
        bad++; $display("FAIL b2b xfer_time[%0d]: got %0d required %0d", b, xfer_t[b], xfer_t[0] + 1 + CPB * 8 * (b - 1));
      end
    end
    check_packet("b2b", 6'd0);
  endtask

  task automatic test_underrun();
    int s; bit ok;
    clear_mon(); pkt = '{8'h3C, 8'h55};
    pulse_start(8'd2, 6'd0, s);
    send_byte(8'h3C, 0, ok);
    wait_idle("underrun");
    check_packet("underrun", 6'd0);
  endtask

  // Second byte offered exactly on the boundary, then one cycle too late.
  task automatic test_boundary();
    int s; bit ok;
    for (int late = 0; late < 2; late++) begin
      clear_mon(); pkt = '{8'hC3, 8'h5A};
      pulse_start(8'd2, 6'd0, s);
      send_byte(8'hC3, 0, ok);
      send_byte(8'h5A, CPB * 8 - 1 + late, ok);
      wait_idle("boundary");
      check_packet(late ? "boundary_late" : "boundary_exact", 6'd0);
    end
  endtask

  task automatic test_busy_and_zero();
    int s, s2; bit ok;
    clear_mon();
    pulse_start(8'd0, 6'd0, s);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (done_t.size() != 1 || done_t[0] != s + 1) begin
      bad++; $display("FAIL zero_len_done: got %0d pulses (first %0d) required 1 at %0d", done_t.size(), (done_t.size() > 0) ? done_t[0] : -1, s + 1);
    end
    total++;
    if (bv_t.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_len_bits: got %0d bits busy=%b required 0,0", bv_t.size(), busy);
    end
    $display("zero_len: start=%0d done_pulses=%0d", s, done_t.size());
    clear_mon(); pkt = '{8'h96};
    pulse_start(8'd1, 6'd0, s);
    pulse_start(8'd0, 6'd0, s2);
    send_byte(8'h96, 0, ok);
    repeat (20) begin @(posedge clk); #1; end
    pulse_start(8'd4, 6'd0, s2);
    pulse_start(8'd0, 6'd0, s2);
    wait_idle("busy_ignore");
    check_packet("busy_ignore", 6'd0);
  endtask

  task automatic test_random();
    int s, len, dly; bit ok;
    for (int it = 0; it < 8; it++) begin
      clear_mon(); pkt.delete();
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) pkt.push_back(8'($urandom));
      pulse_start(8'(len), 6'd0, s);
      for (int b = 0; b < len; b++) begin
        dly = ($urandom_range(0, 7) == 0) ? 150 : $urandom_range(0, 40);
        send_byte(pkt[b], dly, ok);
        if (!ok) break;
      end
      wait_idle("random");
      check_packet("random", 6'd0);
    end
  endtask

  task automatic test_reset_mid();
    int s, n; bit ok;
    clear_mon(); pkt = '{8'hFF};
    pulse_start(8'd1, 6'd0, s);
    send_byte(8'hFF, 0, ok);
    n = 0;
    while (bv_t.size() < 5 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (bv_t.size() < 5) begin
      bad++; $display("FAIL rst_mid_reach: got %0d bits required 5", bv_t.size());
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({byte_ready, phy_bit, bit_valid, bit_valid_last, busy, done, underrun} !== 7'b0) begin
      bad++; $display("FAIL rst_mid_async: got %b required 0000000", {byte_ready, phy_bit, bit_valid, bit_valid_last, busy, done, underrun});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    repeat (300) begin @(posedge clk); #1; end
    total++;
    if (bv_t.size() != 0 || done_t.size() != 0 || und_t.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: got bits=%0d done=%0d underrun=%0d busy=%b required 0,0,0,0", bv_t.size(), done_t.size(), und_t.size(), busy);
    end
    $display("reset_mid: abandoned packet checked");
  endtask

`ifdef TX_WHITENING_EN
  task automatic test_whitening();
    int s; bit ok;
    clear_mon(); pkt = '{8'h00};
    pulse_start(8'd1, 6'd37, s);
    send_byte(8'h00, 0, ok);
    wait_idle("whiten");
    total++;
    if (bv_b.size() < 2 || bv_b[0] !== 1'b1 || bv_b[1] !== 1'b0) begin
      bad++; $display("FAIL whiten_first_bits: got %0d bits, required first two 1,0", bv_b.size());
    end
    check_packet("whiten", 6'd37);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_boundary();
    test_busy_and_zero();
    test_random();
    test_reset_mid();
`ifdef TX_WHITENING_EN
    test_whitening();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_bit_scheduler.md
TX_BIT_SCHEDULER -- requirements
Module: tx_bit_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_PER_SYMBOL, default 8, giving the upsampler ratio; the bit period is CLK_PER_BIT = 2*SAMPLE_PER_SYMBOL clocks (16 clocks = 1 Mbit/s at 16 MHz).
REQ-002 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, a one-cycle request to begin a packet.
REQ-005 SHALL have port pdu_len, input, 8 bits, the packet byte count, sampled on an accepted start.
REQ-006 SHALL have port channel_number, input, 6 bits, the BLE channel index, sampled on an accepted start.
REQ-007 SHALL have port byte_in, input, 8 bits, the packet byte.
REQ-008 SHALL have port byte_valid, input, 1 bit, qualifying byte_in.
REQ-009 SHALL have port byte_ready, output, 1 bit; a byte is transferred when byte_valid and byte_ready are both high.
REQ-010 SHALL have outputs phy_bit, bit_valid and bit_valid_last, 1 bit each, which drive the bit_repeat_upsample inputs of the same names.
REQ-011 SHALL have outputs busy, done and underrun, 1 bit each, as status.

Function
REQ-012 SHALL implement the FSM states IDLE, FETCH, SHIFT, DRAIN.
- IDLE goes to FETCH on start when pdu_len != 0.
- FETCH goes to SHIFT on the first byte transfer.
- SHIFT goes to DRAIN after the last bit.
- DRAIN goes to IDLE after CLK_PER_BIT cycles.
REQ-013 SHALL, on start with pdu_len == 0 in IDLE, emit no bits and pulse done in the following cycle.
REQ-014 SHALL ignore start whenever busy is high; busy = (state != IDLE).
REQ-015 SHALL serialize each byte LSB first.
REQ-016 SHALL assert bit_valid for exactly one cycle per bit.
- The first bit_valid occurs in the cycle after the first byte transfer.
- Each later bit_valid occurs exactly CLK_PER_BIT cycles after the previous one.
REQ-017 SHALL hold phy_bit stable from each bit_valid until the next one.
REQ-018 SHALL assert bit_valid_last in the same cycle as bit_valid for bit 8*pdu_len, and never otherwise.
REQ-019 SHALL hold a one-byte prefetch register.
- byte_ready is high in FETCH.
- byte_ready is high in SHIFT while the prefetch register is empty and bytes remain.
- byte_ready is low otherwise.
REQ-020 SHALL, when the next byte is needed at a bit boundary and the prefetch register is empty:
- pulse underrun for one cycle;
- emit no further bit_valid and no bit_valid_last;
- return to IDLE without pulsing done.
REQ-021 SHALL pulse done for one cycle on the DRAIN to IDLE transition, which occurs CLK_PER_BIT cycles after the bit_valid_last cycle.
REQ-022 SHALL size the bit-period counter as clog2(CLK_PER_BIT) bits, wrapping from CLK_PER_BIT-1 to 0.
REQ-023 SHALL size the remaining-byte counter at 8 bits and never decrement it below 0.
REQ-024 SHALL, when a byte transfer and a bit boundary occur in the same cycle, have the transferred byte satisfy that boundary (no underrun).

Reset
REQ-025 SHALL, while rst_n is low, force the following regardless of clk:
- state = IDLE;
- all counters, shift and prefetch registers = 0;
- byte_ready, phy_bit, bit_valid, bit_valid_last, busy, done, underrun = 0.
REQ-026 SHALL, when reset is asserted mid-packet, abandon the packet silently, with no done and no underrun pulse after release.

Configuration
REQ-027 SHALL, with TX_WHITENING_EN defined, XOR each serialized bit with the output of a 7-bit whitening LFSR w.
- Seed on accepted start: w[0]=1, w[1]=channel_number[5] ... w[6]=channel_number[0].
- phy_bit = data ^ w[6].
- After each bit: w[0]<=w[6], w[4]<=w[3]^w[6], w[k]<=w[k-1] for other k.
REQ-028 SHALL, without TX_WHITENING_EN, output data bits unmodified and contain no LFSR logic; channel_number is then unused.

Structure
REQ-029 SHALL take its FSM state enum, CLK_PER_BIT derivation and whitening seed/tap constants from the shared package btle_tx_pkg.
REQ-030 SHALL place the whitening LFSR in sub-module ble_whiten_lfsr (ports: seed load, step, current output bit), instantiated only under TX_WHITENING_EN.

Verification
REQ-031 Single byte: pdu_len=1, byte 0xA5, whitening off, byte transferred at cycle T.
- phy_bit = 1,0,1,0,0,1,0,1 with bit_valid at T+1, T+17 ... T+113.
- bit_valid_last at T+113; done at T+129.
REQ-032 Back-to-back: pdu_len=3, bytes 0x01,0x80,0xFF with byte_valid held high.
- 24 bit_valid pulses exactly 16 cycles apart; no underrun.
- byte_ready low while the prefetch register is full.
REQ-033 Underrun: pdu_len=2, second byte withheld.
- underrun pulses at the 9th bit boundary; 8 bits only; no bit_valid_last; no done; busy=0 afterwards.
REQ-034 Start during busy is ignored, and pdu_len=0 in IDLE gives done one cycle later with zero bit_valid.
REQ-035 Reset mid-packet: rst_n low at bit 5 of 0xFF.
- All outputs 0 immediately, without waiting for clk.
- After release, no further bits, done or underrun until the next start.
REQ-036 Whitening (TX_WHITENING_EN): channel_number=37, byte 0x00.
- First two phy_bit values are 1,0; the full 8-bit sequence matches the bench LFSR model.
